eth_header_parser: RTL and testbench
====================================

// Module: eth_header_parser
// PURPOSE
//  Snoops the ingress Ethernet byte stream, walks the L2 header and extracts dst MAC, src MAC and the
//  EtherType, skipping up to MAX_VLAN_TAGS 802.1Q/802.1ad tags. Sits directly upstream of the type field
//  checker and feeds it through type_pkt. Also raises a per-frame length verdict on hdr_drop.
//  Pure tap: never stalls or alters the stream.
// PARAMETERS
//  MAX_VLAN_TAGS  2   tags skipped before EtherType (0 = no VLAN parsing)
//  MIN_FRAME_LEN  60  min bytes per frame (excl. FCS); shorter -> hdr_drop.tuser=1
//  LEN_W          11  frame byte counter width; saturates at 2**LEN_W-1
// PORTS
//  clk          in   1   clock; all logic on posedge
//  reset        in   1   asynchronous, active-low reset
//  in_tdata     in   8   ingress frame byte
//  in_tvalid    in   1   ingress beat valid
//  in_tlast     in   1   last byte of frame
//  in_tready    in   1   downstream ready; beat accepted when in_tvalid & in_tready
//  dst_mac      out  48  destination MAC, byte 0 in [47:40]; held until next frame's capture
//  src_mac      out  48  source MAC, same ordering
//  mac_valid    out  1   1-cycle pulse, same cycle as type_pkt.tvalid
//  type_pkt     out  packet_source_t  tdata[15:0]=EtherType; tvalid 1-cycle pulse; tuser=1 if >=1 VLAN tag
//  hdr_drop     out  drop_source_t    tvalid 1-cycle pulse per frame; tuser=1 -> drop frame
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state=DST, counters 0, all valids 0, MACs/tdata 0, tuser 0.
//    First accepted beat after reset is byte 0 of a frame; upstream is reset together.
//  - Only accepted beats advance state. No backpressure is generated.
//  - FSM: DST (6 B) -> SRC (6 B) -> TYPE_HI -> TYPE_LO -> {TCI_HI -> TCI_LO -> TYPE_HI | PAYLOAD}.
//    In TYPE_LO: if {hi,lo} in {TPID_8021Q, TPID_8021AD} and vlan_cnt<MAX_VLAN_TAGS, go to TCI_HI
//    and increment vlan_cnt. Else latch the EtherType, go to PAYLOAD.
//    PAYLOAD waits for tlast.
//  - Any accepted tlast returns the FSM to DST and clears vlan_cnt and the byte count.
//  - Too many tags: a TPID seen with vlan_cnt==MAX_VLAN_TAGS is reported as the EtherType
//    (tdata=TPID, tuser=1).
//  - Latency: type_pkt.tvalid and mac_valid assert the cycle after the TYPE_LO beat is accepted.
//    Exactly one pulse per frame whose header completes.
//  - Byte count: LEN_W-bit saturating, counts accepted beats incl. the tlast beat.
//  - hdr_drop asserts the cycle after the tlast beat. tuser=1 if count<MIN_FRAME_LEN or the header
//    was incomplete (tlast before/at a state other than PAYLOAD, excluding tlast on TYPE_LO).
//  - tlast on the TYPE_LO beat: type_pkt and hdr_drop pulse together next cycle. Length rule still
//    applies (14-byte frame -> tuser=1).
//  - Runt ending before TYPE_LO: no type_pkt, no mac_valid; hdr_drop.tuser=1.
//  - Back-to-back frames: byte after tlast is byte 0 of the next frame, with no idle cycle required.
//  - Reset mid-frame: outputs clear immediately; the partial frame produces no pulses.
// STRUCTURE
//  - filter_defs.svh: TPID_8021Q=16'h8100, TPID_8021AD=16'h88A8, ETH_MAC_BYTES=6,
//    hdr_state_e enum (DST,SRC,TYPE_HI,TYPE_LO,TCI_HI,TCI_LO,PAYLOAD).
//  - packet_source_t / drop_source_t from packet_filter.svh.
//  - Single flat module; byte-index counter (3 b) shared by DST/SRC shift-in. No sub-modules.
// TESTING
//  1. 64-byte untagged frame, type 0x0800, in_tready=1 -> one type_pkt {0x0800, tuser=0} one cycle
//     after byte 13; dst/src MACs match; hdr_drop {valid, tuser=0} after byte 63.
//  2. Single tag 0x8100/TCI 0x0005, inner type 0x86DD, 68 bytes -> type_pkt {0x86DD, tuser=1}
//     after byte 17; hdr_drop tuser=0.
//  3. Three stacked TPIDs 0x88A8,0x8100,0x8100 with MAX_VLAN_TAGS=2 -> type_pkt {0x8100, tuser=1}
//     after byte 21; FSM in PAYLOAD.
//  4. 10-byte frame (tlast on byte 9) -> no type_pkt/mac_valid; hdr_drop tuser=1.
//     Next frame parses correctly with no gap.
//  5. Random in_tvalid/in_tready stalls on frame 1 -> same outputs as without stalls; no pulse
//     during stalled cycles.
//  6. reset low at byte 8, high 3 cycles later, then a fresh 60-byte frame -> no pulses from the
//     partial frame; new frame hdr_drop tuser=0.

Source files
------------

// File: rtl/eth_header_parser_pkg.sv
// Shared definitions for the Ethernet L2 header parser: TPIDs, FSM states and
// the sideband record types driven towards the type checker and drop logic.
package eth_header_parser_pkg;

  localparam logic [15:0] TPID_8021Q    = 16'h8100;
  localparam logic [15:0] TPID_8021AD   = 16'h88A8;
  localparam int unsigned ETH_MAC_BYTES = 6;

  typedef enum logic [2:0] {
    DST,
    SRC,
    TYPE_HI,
    TYPE_LO,
    TCI_HI,
    TCI_LO,
    PAYLOAD
  } hdr_state_e;

  typedef struct packed {
    logic [15:0] tdata;
    logic        tvalid;
    logic        tuser;
  } packet_source_t;

  typedef struct packed {
    logic tvalid;
    logic tuser;
  } drop_source_t;

  function automatic logic is_tpid(input logic [15:0] word);
    return (word == TPID_8021Q) || (word == TPID_8021AD);
  endfunction

endpackage

// File: rtl/eth_header_parser.sv
// Passive tap on the ingress byte stream: extracts MACs and EtherType (skipping
// VLAN tags) and issues a per-frame length/completeness verdict.
module eth_header_parser
  import eth_header_parser_pkg::*;
#(
  parameter int unsigned MAX_VLAN_TAGS = 2,
  parameter int unsigned MIN_FRAME_LEN = 60,
  parameter int unsigned LEN_W         = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     in_tdata,
  input  logic           in_tvalid,
  input  logic           in_tlast,
  input  logic           in_tready,
  output logic [47:0]    dst_mac,
  output logic [47:0]    src_mac,
  output logic           mac_valid,
  output packet_source_t type_pkt,
  output drop_source_t   hdr_drop
);

  localparam int unsigned        VLAN_W   = $clog2(MAX_VLAN_TAGS + 2);
  localparam logic [VLAN_W-1:0]  VLAN_MAX = VLAN_W'(MAX_VLAN_TAGS);
  localparam logic [LEN_W-1:0]   MIN_LEN  = LEN_W'(MIN_FRAME_LEN);
  localparam logic [2:0]         MAC_LAST = 3'(ETH_MAC_BYTES - 1);

  hdr_state_e        state;
  logic [2:0]        byte_idx;
  logic [VLAN_W-1:0] vlan_cnt;
  logic [LEN_W-1:0]  len_cnt;
  logic [7:0]        type_hi;

  logic              beat;
  logic              tpid_seen;
  logic              tag_push;
  logic              hdr_ok;
  logic [LEN_W-1:0]  len_next;

  assign beat      = in_tvalid & in_tready;
  assign tpid_seen = is_tpid({type_hi, in_tdata});
  assign tag_push  = tpid_seen && (vlan_cnt < VLAN_MAX);
  assign len_next  = (len_cnt == '1) ? len_cnt : len_cnt + 1'b1;
  // A frame ending on the EtherType beat still counts as a complete header.
  assign hdr_ok    = (state == PAYLOAD) || ((state == TYPE_LO) && !tag_push);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DST;
      byte_idx  <= '0;
      vlan_cnt  <= '0;
      len_cnt   <= '0;
      type_hi   <= '0;
      dst_mac   <= '0;
      src_mac   <= '0;
      mac_valid <= 1'b0;
      type_pkt  <= '0;
      hdr_drop  <= '0;
    end else begin
      mac_valid       <= 1'b0;
      type_pkt.tvalid <= 1'b0;
      hdr_drop.tvalid <= 1'b0;

      if (beat) begin
        len_cnt <= len_next;

        case (state)
          DST: begin
            dst_mac <= {dst_mac[39:0], in_tdata};
            if (byte_idx == MAC_LAST) begin
              byte_idx <= '0;
              state    <= SRC;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          SRC: begin
            src_mac <= {src_mac[39:0], in_tdata};
            if (byte_idx == MAC_LAST) begin
              byte_idx <= '0;
              state    <= TYPE_HI;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          TYPE_HI: begin
            type_hi <= in_tdata;
            state   <= TYPE_LO;
          end
          TYPE_LO: begin
            if (tag_push) begin
              vlan_cnt <= vlan_cnt + 1'b1;
              state    <= TCI_HI;
            end else begin
              // An excess TPID is reported as the EtherType, flagged as tagged.
              type_pkt.tdata  <= {type_hi, in_tdata};
              type_pkt.tuser  <= (vlan_cnt != '0) | tpid_seen;
              type_pkt.tvalid <= 1'b1;
              mac_valid       <= 1'b1;
              state           <= PAYLOAD;
            end
          end
          TCI_HI:  state <= TCI_LO;
          TCI_LO:  state <= TYPE_HI;
          PAYLOAD: state <= PAYLOAD;
          default: state <= DST;
        endcase

        if (in_tlast) begin
          state           <= DST;
          byte_idx        <= '0;
          vlan_cnt        <= '0;
          len_cnt         <= '0;
          hdr_drop.tvalid <= 1'b1;
          hdr_drop.tuser  <= (len_next < MIN_LEN) | ~hdr_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_header_parser.sv
// Directed bench for eth_header_parser: untagged, tagged, over-tagged, runt,
// stalled, short-boundary and mid-frame reset cases.
module tb_eth_header_parser;
  import eth_header_parser_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [7:0]     in_tdata = '0;
  logic           in_tvalid = 1'b0;
  logic           in_tlast = 1'b0;
  logic           in_tready = 1'b0;
  logic [47:0]    dst_mac;
  logic [47:0]    src_mac;
  logic           mac_valid;
  packet_source_t type_pkt;
  drop_source_t   hdr_drop;

  int checks = 0;
  int errors = 0;

  eth_header_parser #(
    .MAX_VLAN_TAGS(2),
    .MIN_FRAME_LEN(60),
    .LEN_W(11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_tdata(in_tdata),
    .in_tvalid(in_tvalid),
    .in_tlast(in_tlast),
    .in_tready(in_tready),
    .dst_mac(dst_mac),
    .src_mac(src_mac),
    .mac_valid(mac_valid),
    .type_pkt(type_pkt),
    .hdr_drop(hdr_drop)
  );

  always #5 clk = ~clk;

  // Frame-relative beat tracking and pulse logging
  int          fbeat = 0;
  int          last_beat = -1;
  bit          acc_edge = 1'b0;
  int          stray = 0;
  int          type_beat[$];
  logic [15:0] type_data[$];
  bit          type_user[$];
  int          mac_beat[$];
  int          drop_beat[$];
  bit          drop_user[$];

  always @(posedge clk) begin
    acc_edge = in_tvalid && in_tready && reset;
    if (!reset) begin
      fbeat = 0;
    end else if (acc_edge) begin
      last_beat = fbeat;
      fbeat = in_tlast ? 0 : fbeat + 1;
    end
  end

  always @(negedge clk) begin
    if (type_pkt.tvalid) begin
      type_beat.push_back(last_beat);
      type_data.push_back(type_pkt.tdata);
      type_user.push_back(type_pkt.tuser);
      if (!acc_edge) stray++;
    end
    if (mac_valid) begin
      mac_beat.push_back(last_beat);
      if (!acc_edge) stray++;
    end
    if (hdr_drop.tvalid) begin
      drop_beat.push_back(last_beat);
      drop_user.push_back(hdr_drop.tuser);
      if (!acc_edge) stray++;
    end
  end

  logic [8:0] fr[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    type_beat.delete(); type_data.delete(); type_user.delete();
    mac_beat.delete(); drop_beat.delete(); drop_user.delete();
    stray = 0;
  endtask

  task automatic add_mac(input logic [47:0] m);
    for (int i = 5; i >= 0; i--) fr.push_back({1'b0, m[i*8 +: 8]});
  endtask

  task automatic add16(input logic [15:0] w);
    fr.push_back({1'b0, w[15:8]});
    fr.push_back({1'b0, w[7:0]});
  endtask

  // Pads the current frame (starting at base) to n bytes and marks its last byte.
  task automatic end_frame(input int base, input int n);
    logic [8:0] b;
    while (fr.size() - base < n) fr.push_back({1'b0, 8'(fr.size() - base)});
    b = fr[fr.size() - 1];
    b[8] = 1'b1;
    fr[fr.size() - 1] = b;
  endtask

  task automatic send(input int lo, input int hi, input bit stall);
    for (int i = lo; i <= hi; i++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          in_tvalid = 1'($urandom_range(0, 1));
          in_tready = in_tvalid ? 1'b0 : 1'($urandom_range(0, 1));
          in_tdata  = 8'($urandom);
          in_tlast  = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      in_tvalid = 1'b1;
      in_tready = 1'b1;
      in_tdata  = fr[i][7:0];
      in_tlast  = fr[i][8];
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // One type pulse at tbeat and one verdict at dbeat
  task automatic check_frame(input string tag, input int tbeat, input logic [15:0] tdata,
                             input bit tuser, input int dbeat, input bit duser);
    check({tag, "_type_n"}, 64'(type_beat.size()), 64'd1);
    check({tag, "_mac_n"}, 64'(mac_beat.size()), 64'd1);
    check({tag, "_drop_n"}, 64'(drop_beat.size()), 64'd1);
    if (type_beat.size() == 1) begin
      check({tag, "_type_beat"}, 64'(type_beat[0]), 64'(tbeat));
      check({tag, "_type_data"}, 64'(type_data[0]), 64'(tdata));
      check({tag, "_type_user"}, 64'(type_user[0]), 64'(tuser));
    end
    if (mac_beat.size() == 1) check({tag, "_mac_beat"}, 64'(mac_beat[0]), 64'(tbeat));
    if (drop_beat.size() == 1) begin
      check({tag, "_drop_beat"}, 64'(drop_beat[0]), 64'(dbeat));
      check({tag, "_drop_user"}, 64'(drop_user[0]), 64'(duser));
    end
    check({tag, "_stray"}, 64'(stray), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dst", 64'(dst_mac), 64'd0);
    check("rst_src", 64'(src_mac), 64'd0);
    check("rst_type", 64'(type_pkt), 64'd0);
    check("rst_drop", 64'(hdr_drop), 64'd0);
    check("rst_macv", 64'(mac_valid), 64'd0);
    check("rst_state", 64'(dut.state), 64'(DST));
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: 64-byte untagged IPv4
    fr.delete(); clr_log();
    add_mac(48'h02_11_22_33_44_55); add_mac(48'h02_AA_BB_CC_DD_EE); add16(16'h0800);
    end_frame(0, 64);
    send(0, 63, 1'b0); settle();
    check_frame("t1", 13, 16'h0800, 1'b0, 63, 1'b0);
    check("t1_dst", 64'(dst_mac), 64'h0211_2233_4455);
    check("t1_src", 64'(src_mac), 64'h02AA_BBCC_DDEE);

    // 2: single 802.1Q tag, inner IPv6, 68 bytes
    fr.delete(); clr_log();
    add_mac(48'hFF_FF_FF_FF_FF_FF); add_mac(48'h00_01_02_03_04_05);
    add16(16'h8100); add16(16'h0005); add16(16'h86DD);
    end_frame(0, 68);
    send(0, 67, 1'b0); settle();
    check_frame("t2", 17, 16'h86DD, 1'b1, 67, 1'b0);
    check("t2_dst", 64'(dst_mac), 64'hFFFF_FFFF_FFFF);

    // 3: three stacked TPIDs, only two skipped
    fr.delete(); clr_log();
    add_mac(48'h00_00_5E_00_01_01); add_mac(48'h00_00_5E_00_01_02);
    add16(16'h88A8); add16(16'h0064); add16(16'h8100); add16(16'h00C8);
    add16(16'h8100); add16(16'h0800);
    end_frame(0, 64);
    send(0, 21, 1'b0); settle();
    check("t3_state", 64'(dut.state), 64'(PAYLOAD));
    send(22, 63, 1'b0); settle();
    check_frame("t3", 21, 16'h8100, 1'b1, 63, 1'b0);

    // 4: 10-byte runt followed with no gap by a 64-byte ARP frame
    fr.delete(); clr_log();
    add_mac(48'h01_02_03_04_05_06); add16(16'h0708); add16(16'h090A);
    end_frame(0, 10);
    add_mac(48'h10_20_30_40_50_60); add_mac(48'h70_80_90_A0_B0_C0); add16(16'h0806);
    end_frame(10, 64);
    send(0, 73, 1'b0); settle();
    check("t4_type_n", 64'(type_beat.size()), 64'd1);
    check("t4_drop_n", 64'(drop_beat.size()), 64'd2);
    if (drop_beat.size() == 2) begin
      check("t4_runt_beat", 64'(drop_beat[0]), 64'd9);
      check("t4_runt_user", 64'(drop_user[0]), 64'd1);
      check("t4_next_beat", 64'(drop_beat[1]), 64'd63);
      check("t4_next_user", 64'(drop_user[1]), 64'd0);
    end
    if (type_beat.size() == 1) begin
      check("t4_type_beat", 64'(type_beat[0]), 64'd13);
      check("t4_type_data", 64'(type_data[0]), 64'h0806);
    end
    check("t4_dst", 64'(dst_mac), 64'h1020_3040_5060);

    // 5: frame 1 again with random stalls
    fr.delete(); clr_log();
    add_mac(48'h02_11_22_33_44_55); add_mac(48'h02_AA_BB_CC_DD_EE); add16(16'h0800);
    end_frame(0, 64);
    send(0, 63, 1'b1); settle();
    check_frame("t5", 13, 16'h0800, 1'b0, 63, 1'b0);
    check("t5_src", 64'(src_mac), 64'h02AA_BBCC_DDEE);

    // 14-byte frame ends on the EtherType byte; 59 bytes is one short
    fr.delete(); clr_log();
    add_mac(48'hAA_00_00_00_00_01); add_mac(48'hBB_00_00_00_00_02); add16(16'h0800);
    end_frame(0, 14);
    send(0, 13, 1'b0); settle();
    check_frame("t14", 13, 16'h0800, 1'b0, 13, 1'b1);
    fr.delete(); clr_log();
    add_mac(48'hAA_00_00_00_00_01); add_mac(48'hBB_00_00_00_00_02); add16(16'h0800);
    end_frame(0, 59);
    send(0, 58, 1'b0); settle();
    check_frame("t59", 13, 16'h0800, 1'b0, 58, 1'b1);

    // 6: reset at byte 8, then a fresh 60-byte frame
    fr.delete(); clr_log();
    add_mac(48'h0C_0D_0E_0F_10_11); add_mac(48'h12_13_14_15_16_17); add16(16'h0800);
    end_frame(0, 60);
    send(0, 7, 1'b0);
    reset = 1'b0;
    #1;
    check("t6_rst_dst", 64'(dst_mac), 64'd0);
    check("t6_rst_src", 64'(src_mac), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_partial_pulses", 64'(type_beat.size() + drop_beat.size() + mac_beat.size()), 64'd0);
    send(0, 59, 1'b0); settle();
    check_frame("t6", 13, 16'h0800, 1'b0, 59, 1'b0);
    check("t6_dst", 64'(dst_mac), 64'h0C0D_0E0F_1011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
